// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Default 640x480@60 timing constants and counter-width helper
//               shared by the VGA timing controller files. Contains no logic.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    // 640x480@60 Hz, 25.175 MHz pixel clock
    localparam int C_H_DISPLAY = 640;
    localparam int C_H_FRONT   = 16;
    localparam int C_H_SYNC    = 96;
    localparam int C_H_BACK    = 48;
    localparam int C_V_DISPLAY = 480;
    localparam int C_V_FRONT   = 10;
    localparam int C_V_SYNC    = 2;
    localparam int C_V_BACK    = 33;

    // Width of a counter spanning 0..n-1; never narrower than one bit so a
    // degenerate count of 1 still yields a legal vector.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : vga_pkg
`default_nettype wire

// File: rtl/vga_timing_ctrl_pixel_tick.sv
`default_nettype none
// ============================================================================
// Module      : vga_pixel_tick
// Description : Clock divider producing a one-cycle pixel strobe every
//               CLK_DIV clk cycles.
// Ports       : clk      - single clock
//               rst      - synchronous active-high reset
//               pixel_en - high in the cycle the divider reaches CLK_DIV-1
// Revision    : 1.0 - initial release
// ============================================================================
module vga_pixel_tick
    import vga_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic pixel_en
);

    localparam int            CW     = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    if (CLK_DIV < 1) begin : g_err_clk_div
        $error("vga_pixel_tick: CLK_DIV must be >= 1");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == C_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Gated by rst so the strobe is low during reset even when CLK_DIV=1,
    // where the counter never leaves its terminal value.
    assign pixel_en = ~rst & (r_cnt == C_LAST);

endmodule : vga_pixel_tick
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_ctrl
// Description : VGA raster timing generator. Produces pixel/line/frame
//               strobes, x/y raster position, and a registered output stage
//               carrying sync and blanked colour with one pixel tick latency.
// Ports       : clk, rst                    - clock, synchronous reset
//               red_in/green_in/blue_in     - colour for current x, y
//               hsync, vsync                - registered sync outputs
//               red, green, blue            - registered, blanked colour
//               x, y                        - raster counters
//               display_on                  - current x, y is visible
//               pixel_en                    - pixel tick
//               line_start, frame_start     - first pixel of line / frame
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_ctrl
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = C_H_DISPLAY,
    parameter int H_FRONT   = C_H_FRONT,
    parameter int H_SYNC    = C_H_SYNC,
    parameter int H_BACK    = C_H_BACK,
    parameter int V_DISPLAY = C_V_DISPLAY,
    parameter int V_FRONT   = C_V_FRONT,
    parameter int V_SYNC    = C_V_SYNC,
    parameter int V_BACK    = C_V_BACK,
    parameter int CLK_DIV   = 1,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int COLOR_W   = 2,
    localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_SYNC + V_BACK,
    localparam int XW       = cnt_width(H_TOTAL),
    localparam int YW       = cnt_width(V_TOTAL)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COLOR_W-1:0] red_in,
    input  logic [COLOR_W-1:0] green_in,
    input  logic [COLOR_W-1:0] blue_in,
    output logic               hsync,
    output logic               vsync,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic [XW-1:0]      x,
    output logic [YW-1:0]      y,
    output logic               display_on,
    output logic               pixel_en,
    output logic               line_start,
    output logic               frame_start
);

    // Raster landmarks, sized to the counters to keep comparisons exact.
    localparam logic [XW-1:0] C_X_LAST     = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] C_X_DISP     = XW'(H_DISPLAY);
    localparam logic [XW-1:0] C_HS_FIRST   = XW'(H_DISPLAY + H_FRONT);
    localparam logic [XW-1:0] C_HS_LAST    = XW'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [YW-1:0] C_Y_LAST     = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] C_Y_DISP     = YW'(V_DISPLAY);
    localparam logic [YW-1:0] C_VS_FIRST   = YW'(V_DISPLAY + V_FRONT);
    localparam logic [YW-1:0] C_VS_LAST    = YW'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    if (CLK_DIV < 1) begin : g_err_clk_div
        $error("vga_timing_ctrl: CLK_DIV must be >= 1");
    end

    if (H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1) begin : g_err_timing
        $error("vga_timing_ctrl: porch and sync widths must be >= 1");
    end

    logic               w_pixel_en;
    logic               w_x_last;
    logic               w_y_last;
    logic               w_display_on;
    logic               w_hs_act;
    logic               w_vs_act;
    logic [XW-1:0]      r_x;
    logic [YW-1:0]      r_y;
    logic               r_hsync;
    logic               r_vsync;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_green;
    logic [COLOR_W-1:0] r_blue;

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_pixel_tick (
        .clk      (clk),
        .rst      (rst),
        .pixel_en (w_pixel_en)
    );

    assign w_x_last = (r_x == C_X_LAST);
    assign w_y_last = (r_y == C_Y_LAST);

    // Raster counters: y only advances on the tick where x wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_pixel_en) begin
            if (w_x_last) begin
                r_x <= '0;
                r_y <= w_y_last ? '0 : r_y + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    assign w_display_on = (r_x < C_X_DISP) && (r_y < C_Y_DISP);
    assign w_hs_act     = (r_x >= C_HS_FIRST) && (r_x <= C_HS_LAST);
    // Depends on y alone, so vsync always spans whole lines.
    assign w_vs_act     = (r_y >= C_VS_FIRST) && (r_y <= C_VS_LAST);

    // Output stage: capturing on the pixel tick keeps sync and colour aligned
    // one tick behind the counters and ignores *_in between ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hsync <= ~HSYNC_POL;
            r_vsync <= ~VSYNC_POL;
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
        end else if (w_pixel_en) begin
            r_hsync <= ~(w_hs_act ^ HSYNC_POL);
            r_vsync <= ~(w_vs_act ^ VSYNC_POL);
            r_red   <= w_display_on ? red_in   : '0;
            r_green <= w_display_on ? green_in : '0;
            r_blue  <= w_display_on ? blue_in  : '0;
        end
    end

    assign hsync       = r_hsync;
    assign vsync       = r_vsync;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;
    assign x           = r_x;
    assign y           = r_y;
    assign display_on  = w_display_on;
    assign pixel_en    = w_pixel_en;
    assign line_start  = w_pixel_en && (r_x == '0);
    assign frame_start = w_pixel_en && (r_x == '0) && (r_y == '0);

endmodule : vga_timing_ctrl
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_ctrl
// Description : Directed self-checking bench for vga_timing_ctrl. Three
//               instances: small raster with CLK_DIV=2 (A), default 640x480
//               with CLK_DIV=1 and positive hsync (B), small raster with
//               CLK_DIV=3 and glitching colour inputs (C).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance A: small mode, CLK_DIV=2 ----------------
    logic       rst_a = 1'b1;
    logic [1:0] ri_a = '0, gi_a = '0, bi_a = '0;
    logic       hs_a, vs_a, don_a, pe_a, ls_a, fs_a;
    logic [1:0] r_a, g_a, b_a;
    logic [3:0] x_a;
    logic [2:0] y_a;

    vga_timing_ctrl #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(2), .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .COLOR_W(2)
    ) u_dut_a (
        .clk(clk), .rst(rst_a), .red_in(ri_a), .green_in(gi_a), .blue_in(bi_a),
        .hsync(hs_a), .vsync(vs_a), .red(r_a), .green(g_a), .blue(b_a),
        .x(x_a), .y(y_a), .display_on(don_a), .pixel_en(pe_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    // ---------------- instance B: default timing, CLK_DIV=1, hsync active-high
    logic       rst_b = 1'b1;
    logic [1:0] ri_b = '0, gi_b = '0, bi_b = '0;
    logic       hs_b, vs_b, don_b, pe_b, ls_b, fs_b;
    logic [1:0] r_b, g_b, b_b;
    logic [9:0] x_b;
    logic [9:0] y_b;

    vga_timing_ctrl #(
        .CLK_DIV(1), .HSYNC_POL(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst_b), .red_in(ri_b), .green_in(gi_b), .blue_in(bi_b),
        .hsync(hs_b), .vsync(vs_b), .red(r_b), .green(g_b), .blue(b_b),
        .x(x_b), .y(y_b), .display_on(don_b), .pixel_en(pe_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    // ---------------- instance C: small mode, CLK_DIV=3 ----------------
    logic       rst_c = 1'b1;
    logic [1:0] ri_c = '0, gi_c = '0, bi_c = '0;
    logic       hs_c, vs_c, don_c, pe_c, ls_c, fs_c;
    logic [1:0] r_c, g_c, b_c;
    logic [3:0] x_c;
    logic [2:0] y_c;

    vga_timing_ctrl #(
        .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(2), .H_BACK(2),
        .V_DISPLAY(4), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
        .CLK_DIV(3), .COLOR_W(2)
    ) u_dut_c (
        .clk(clk), .rst(rst_c), .red_in(ri_c), .green_in(gi_c), .blue_in(bi_c),
        .hsync(hs_c), .vsync(vs_c), .red(r_c), .green(g_c), .blue(b_c),
        .x(x_c), .y(y_c), .display_on(don_c), .pixel_en(pe_c),
        .line_start(ls_c), .frame_start(fs_c)
    );

    // Advance instance A until a pixel_en cycle at (xx, yy); bounded.
    task automatic wait_a(input int xx, input int yy, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            tick();
            if (pe_a && x_a == 4'(xx) && y_a == 3'(yy)) found = 1'b1;
        end
        check(tag, 32'(found), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ex, ey, lx, ly, gap, t, fs_t0, fs_t1, fs_n;
        int e_x, e_y, e_gap, e_sync, e_col, e_don, e_ls, e_fs, max_x, max_y;
        logic [1:0] er, eg, eb, good;
        bit have;

        repeat (3) tick();

        // ---- reset state ----
        check("a_rst_x", 32'(x_a), 0);
        check("a_rst_y", 32'(y_a), 0);
        check("a_rst_pe", 32'(pe_a), 0);
        check("a_rst_ls", 32'(ls_a), 0);
        check("a_rst_fs", 32'(fs_a), 0);
        check("a_rst_hs", 32'(hs_a), 1);
        check("a_rst_vs", 32'(vs_a), 1);
        check("a_rst_red", 32'(r_a), 0);
        check("b_rst_pe", 32'(pe_b), 0);
        check("b_rst_hs", 32'(hs_b), 0);
        check("b_rst_vs", 32'(vs_b), 1);
        check("c_rst_pe", 32'(pe_c), 0);

        // ---- A: release, first tick, one full sweep of two frames ----
        ri_a = 2'd3; gi_a = 2'd2; bi_a = 2'd1;
        rst_a = 1'b0;
        #1;
        check("a_first_cycle_pe", 32'(pe_a), 0);
        tick();
        check("a_first_pe", 32'(pe_a), 1);
        check("a_first_fs", 32'(fs_a), 1);

        ex = 1; ey = 0; lx = 0; ly = 0; gap = 0;
        e_x = 0; e_y = 0; e_gap = 0; e_sync = 0; e_col = 0; e_don = 0;
        e_ls = 0; e_fs = 0; max_x = 0; max_y = 0; fs_t0 = 0; fs_t1 = 0; fs_n = 0;
        for (t = 1; t <= 400; t++) begin
            tick();
            gap++;
            if (hs_a !== !(lx == 10 || lx == 11)) e_sync++;
            if (vs_a !== !(ly == 5)) e_sync++;
            if (lx < 8 && ly < 4) begin er = 2'd3; eg = 2'd2; eb = 2'd1; end
            else begin er = 2'd0; eg = 2'd0; eb = 2'd0; end
            if (r_a !== er || g_a !== eg || b_a !== eb) e_col++;
            if (don_a !== (x_a < 8 && y_a < 4)) e_don++;
            if (ls_a !== (pe_a && x_a == 0)) e_ls++;
            if (fs_a !== (pe_a && x_a == 0 && y_a == 0)) e_fs++;
            if (32'(x_a) != ex) e_x++;
            if (32'(y_a) != ey) e_y++;
            if (pe_a) begin
                if (gap != 2) e_gap++;
                gap = 0;
                lx = 32'(x_a); ly = 32'(y_a);
                if (lx > max_x) max_x = lx;
                if (ly > max_y) max_y = ly;
                if (fs_a) begin
                    fs_n++;
                    if (fs_n == 1) fs_t0 = t;
                    if (fs_n == 2) fs_t1 = t;
                end
                if (ex == 13) begin ex = 0; ey = (ey == 6) ? 0 : ey + 1; end
                else ex = ex + 1;
            end
        end
        check("a_x_seq", 32'(e_x), 0);
        check("a_y_seq", 32'(e_y), 0);
        check("a_pe_every2", 32'(e_gap), 0);
        check("a_sync_window", 32'(e_sync), 0);
        check("a_colour_blank", 32'(e_col), 0);
        check("a_display_on", 32'(e_don), 0);
        check("a_line_start", 32'(e_ls), 0);
        check("a_frame_start", 32'(e_fs), 0);
        check("a_x_max", 32'(max_x), 13);
        check("a_y_max", 32'(max_y), 6);
        check("a_frame_count", 32'(fs_n), 2);
        check("a_frame_period", 32'(fs_t1 - fs_t0), 196);
        check("a_frame_first_t", 32'(fs_t0), 196);

        // ---- A: colour boundaries ----
        wait_a(8, 0, "a_find_x8");
        check("a_col_before_hedge", 32'(r_a), 3);
        tick();
        check("a_col_hedge_red", 32'(r_a), 0);
        check("a_col_hedge_green", 32'(g_a), 0);
        wait_a(1, 3, "a_find_y3");
        check("a_col_last_line_g", 32'(g_a), 2);
        check("a_col_last_line_b", 32'(b_a), 1);
        wait_a(1, 4, "a_find_y4");
        check("a_col_vedge", 32'(r_a), 0);

        // ---- A: reset mid-frame at x=5, y=2 ----
        wait_a(5, 2, "a_find_x5y2");
        check("a_pre_rst_red", 32'(r_a), 3);
        rst_a = 1'b1;
        #1;
        check("a_rst_pe_gated", 32'(pe_a), 0);
        tick();
        check("a_mid_rst_x", 32'(x_a), 0);
        check("a_mid_rst_y", 32'(y_a), 0);
        check("a_mid_rst_red", 32'(r_a), 0);
        check("a_mid_rst_blue", 32'(b_a), 0);
        check("a_mid_rst_hs", 32'(hs_a), 1);
        check("a_mid_rst_vs", 32'(vs_a), 1);
        rst_a = 1'b0;
        #1;
        check("a_post_rst_pe0", 32'(pe_a), 0);
        tick();
        check("a_post_rst_fs", 32'(fs_a), 1);
        check("a_post_rst_x", 32'(x_a), 0);

        // ---- B: default timing, CLK_DIV=1, hsync active-high ----
        rst_b = 1'b0;
        #1;
        check("b_first_pe", 32'(pe_b), 1);
        check("b_first_fs", 32'(fs_b), 1);
        begin
            int run, first_run, rise_x, ls_t0, ls_t1, ls_n, pe_low;
            run = 0; first_run = -1; rise_x = -1; ls_t0 = 0; ls_t1 = 0;
            ls_n = 1; pe_low = 0;
            for (int i = 1; i <= 1700; i++) begin
                logic prev_hs;
                prev_hs = hs_b;
                tick();
                if (!pe_b) pe_low++;
                if (hs_b && !prev_hs && rise_x < 0) rise_x = 32'(x_b);
                if (hs_b) run++;
                else begin
                    if (run > 0 && first_run < 0) first_run = run;
                    run = 0;
                end
                if (ls_b) begin
                    ls_n++;
                    if (ls_n == 2) ls_t0 = i;
                    if (ls_n == 3) ls_t1 = i;
                end
                if (i == 800) check("b_y_after_line", 32'(y_b), 1);
                if (i == 640) check("b_don_x640", 32'(don_b), 0);
                if (i == 639) check("b_don_x639", 32'(don_b), 1);
            end
            check("b_pe_const", 32'(pe_low), 0);
            check("b_hs_rise_x", 32'(rise_x), 657);
            check("b_hs_width", 32'(first_run), 96);
            check("b_line_first", 32'(ls_t0), 800);
            check("b_line_period", 32'(ls_t1 - ls_t0), 800);
            check("b_vs_idle", 32'(vs_b), 1);
        end

        // ---- C: CLK_DIV=3, inputs glitch outside pixel_en cycles ----
        rst_c = 1'b0;
        have = 1'b0; e_col = 0; e_gap = 0; gap = 0;
        good = 2'd1;
        er = 2'd0; eg = 2'd0; eb = 2'd0;
        ri_c = ~good; gi_c = ~good; bi_c = ~good;
        for (int i = 0; i < 320; i++) begin
            tick();
            gap++;
            if (have && (r_c !== er || g_c !== eg || b_c !== eb)) e_col++;
            if (pe_c) begin
                if (have && gap != 3) e_gap++;
                gap = 0;
                ri_c = good; gi_c = good + 2'd1; bi_c = good + 2'd2;
                if (don_c) begin er = good; eg = good + 2'd1; eb = good + 2'd2; end
                else begin er = 2'd0; eg = 2'd0; eb = 2'd0; end
                have = 1'b1;
                good = good + 2'd1;
            end else begin
                ri_c = ~good; gi_c = ~(good + 2'd1); bi_c = ~(good + 2'd2);
            end
        end
        check("c_colour_sampled", 32'(e_col), 0);
        check("c_pe_every3", 32'(e_gap), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_vga_timing_ctrl
`default_nettype wire

// File: doc/vga_timing_ctrl.md
VGA_TIMING_CTRL -- requirements
Module: vga_timing_ctrl

Interface
REQ-001 Parameters (name, default, meaning) SHALL be exactly:
- H_DISPLAY 640: visible pixels per line.
- H_FRONT 16, H_SYNC 96, H_BACK 48: horizontal porch and sync widths, in pixels.
- V_DISPLAY 480: visible lines.
- V_FRONT 10, V_SYNC 2, V_BACK 33: vertical porch and sync widths, in lines.
- CLK_DIV 1: clk cycles per pixel; must be >= 1.
- HSYNC_POL 0 and VSYNC_POL 0: active level of each sync (0 = active-low).
- COLOR_W 2: bits per colour channel.

REQ-002 Ports (name, direction, width, meaning) SHALL be, clock and reset first:
- clk in 1: single clock.
- rst in 1: synchronous, active-high reset.
- red_in, green_in, blue_in in COLOR_W each: pixel colour for the current x, y.
- hsync out 1, vsync out 1: sync outputs.
- red, green, blue out COLOR_W each: registered colour outputs.
- x out XW: horizontal counter, XW = $clog2(H_TOTAL).
- y out YW: vertical counter, YW = $clog2(V_TOTAL).
- display_on out 1: current x, y is visible.
- pixel_en out 1: pixel tick.
- line_start out 1: first pixel of a line.
- frame_start out 1: first pixel of a frame.

REQ-003 The block SHALL have one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 H_TOTAL SHALL equal H_DISPLAY+H_FRONT+H_SYNC+H_BACK, and V_TOTAL SHALL be the vertical equivalent.
REQ-005 A divider counter SHALL run 0..CLK_DIV-1 and wrap; pixel_en SHALL be high in the cycle the counter equals CLK_DIV-1. With CLK_DIV=1, pixel_en SHALL be constantly 1 outside reset.
REQ-006 x SHALL increment on pixel_en and wrap from H_TOTAL-1 to 0. y SHALL increment only on the pixel_en where x wraps, and SHALL wrap from V_TOTAL-1 to 0.
REQ-007 x and y SHALL hold their values between pixel_en pulses.
REQ-008 display_on SHALL be combinational: (x < H_DISPLAY) && (y < V_DISPLAY).
REQ-009 line_start SHALL equal pixel_en && x==0.
REQ-010 frame_start SHALL equal pixel_en && x==0 && y==0.
REQ-011 Raw hsync SHALL be active for x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]. Raw vsync SHALL be active for y in [V_DISPLAY+V_FRONT, V_DISPLAY+V_FRONT+V_SYNC-1], and SHALL be evaluated over whole lines.
REQ-012 On pixel_en, the output stage SHALL register hsync, vsync and colour. Colour SHALL be the *_in value when display_on, else 0. This gives a latency of exactly one pixel tick, with sync and colour aligned.
REQ-013 Output registers SHALL hold their values between pixel_en pulses.
REQ-014 The sync output level SHALL be the active condition XNOR the POL parameter; the inactive level is ~POL.
REQ-015 When CLK_DIV > 1, *_in SHALL be sampled only in the pixel_en cycle; values at other cycles SHALL be ignored.

Reset
REQ-016 While rst=1, the following SHALL be 0: divider counter, x, y, red, green, blue, pixel_en, line_start and frame_start.
REQ-017 While rst=1, hsync SHALL be ~HSYNC_POL and vsync SHALL be ~VSYNC_POL.
REQ-018 The first pixel_en after rst falls SHALL occur CLK_DIV-1 cycles after the first non-reset cycle; that pulse SHALL carry frame_start=1.
REQ-019 Reset asserted mid-frame SHALL return the block to the REQ-016/017 state on the next clock edge, with no partial line emitted.

Structure
REQ-020 Package vga_pkg SHALL hold the default 640x480@60 timing constants and a function computing the counter widths. The package SHALL contain no logic.
REQ-021 The divider SHALL be a sub-module, vga_pixel_tick (parameter CLK_DIV; ports clk, rst, pixel_en).
REQ-022 Elaboration SHALL fail via $error if CLK_DIV<1 or if any porch or sync parameter is <1.

Verification
REQ-023 Small mode (H 8/2/2/2, V 4/1/1/1, CLK_DIV=2, POL 0) SHALL give the following:
- pixel_en every 2nd clk.
- x sequence 0..13 with wrap.
- y sequence 0..6 with wrap.
- hsync low exactly at x=10,11.
- vsync low exactly on y=5.
- frame_start every 196 clk.
REQ-024 With CLK_DIV=1, HSYNC_POL=1 and default timing, hsync SHALL be high for 96 consecutive clks per 800-clk line, and the frame period SHALL be 420000 clks.
REQ-025 Driving red_in=3, green_in=2, blue_in=1 constantly SHALL give outputs of 3, 2, 1 one pixel tick after display_on rises, and 0 one tick after it falls, including at the x=H_DISPLAY and y=V_DISPLAY boundaries.
REQ-026 Asserting rst for 1 cycle at x=5, y=2 (small mode) SHALL give x=y=0, colour 0 and syncs high on the next edge, followed by a frame_start pulse 1 clk after rst falls.
REQ-027 When *_in toggles on non-pixel_en cycles (CLK_DIV=3), the outputs SHALL reflect only the values present in pixel_en cycles.
